washing_machine_prog: RTL
=========================

Name: washing_machine_prog

Overview:
Parametrised programmable washing-machine controller, successor to the fixed single-program controller.
- Internal tick timers replace the external cycle/spin timeout inputs.
- Program select covers normal, heavy, quick and rinse-only runs; the rinse count is parametrised.
- Fill and drain watchdogs raise a fault.
- Sits between the appliance sensor inputs and the actuator drivers; all actuator outputs are registered.

Parameters:
TIMER_W, 16, width of the internal tick counter
WASH_TICKS, 1000, wash-phase length in clocks (normal mode)
RINSE_TICKS, 500, agitation length of each rinse
SPIN_TICKS, 800, spin length
MAX_RINSE, 3, rinse passes in heavy mode (1..15)
FILL_LIMIT, 2000, max clocks in FILL or DRAIN before fault

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
door_close  in  1  door-closed sensor
start  in  1  start request, level
mode  in  2  program: 0 normal, 1 heavy, 2 quick, 3 rinse-only; sampled on start
filled  in  1  drum full
detergent_added  in  1  detergent dispensed
drained  in  1  drum empty
door_lock  out  1  door latch engaged
motor_on  out  1  agitation motor
fill_valve_on  out  1  inlet valve
drain_valve_on  out  1  drain pump/valve
soap_wash  out  1  soap phase in progress or completed this run
water_wash  out  1  currently in a rinse pass
done  out  1  program complete
fault  out  1  watchdog expired
state  out  3  current state encoding
rinse_left  out  4  remaining rinse passes

Behaviour:
- Reset (async, active-high) forces IDLE and all outputs 0, including counters and the mode register.
- Outputs are Moore, registered: they reflect the state entered on the same edge.
- States (3-bit encoding in the package): IDLE=0, FILL=1, DETERGENT=2, WASH=3, DRAIN=4, SPIN=5, DONE=6, FAULT=7.
- IDLE → FILL:
  - Condition: start && door_close.
  - Latch mode.
  - Load rinse_left: 1 for normal/quick, MAX_RINSE for heavy, 1 for rinse-only.
  - Clear soap_wash. Set soap_wash only when mode≠3.
- FILL:
  - fill_valve_on=1, door_lock=1.
  - When filled=1, go to DETERGENT if soap phase pending (soap_wash=1 and not yet washed); otherwise go to WASH as a rinse (water_wash=1).
- DETERGENT:
  - Holds while detergent_added=0 (door_lock=1).
  - Then go to WASH.
- WASH:
  - motor_on=1.
  - Stays exactly N clocks: WASH_TICKS for normal/heavy soap wash, WASH_TICKS/2 for quick, RINSE_TICKS for rinse passes.
  - Timer is loaded N-1 on entry; exit when timer==0.
  - Then go to DRAIN.
- DRAIN:
  - drain_valve_on=1.
  - When drained=1:
    - After the soap wash: go to FILL for the first rinse.
    - After a rinse: decrement rinse_left. If the result is >0, go to FILL; else go to SPIN.
- SPIN:
  - motor_on=1, drain_valve_on=1.
  - SPIN_TICKS clocks, then DONE.
- DONE:
  - done=1; door_lock=0 when drained=1.
  - Returns to IDLE when door_close=0.
  - start is ignored until back in IDLE.
- Watchdog:
  - Counter runs in FILL and DRAIN.
  - Reaching FILL_LIMIT clocks without filled/drained → FAULT.
- FAULT:
  - fault=1, drain_valve_on=1, door_lock=1 until drained=1, then door_lock=0.
  - Exits only by reset.
- Door opens (door_close=0) in any locked state other than DONE/FAULT: go to FAULT.
- Simultaneous events: filled and watchdog expiry on the same clock → filled wins. Timers saturate and never wrap. Widths are truncated to TIMER_W; tick parameters must fit.
- mode changes mid-run are ignored.

Optional Feature:
PAUSE_EN
- With the macro: adds input pause.
- While pause=1 in WASH or SPIN, motor_on=0 and the timer freezes.
- In FILL/DRAIN the valves close and the watchdog freezes.
- door_lock stays 1. Resume continues the same state with the remaining count.
- Without the macro: no pause port, no pause logic.

Decomposition:
- Shared package washer_pkg holds:
  - state encoding constants
  - mode constants (MODE_NORMAL, MODE_HEAVY, MODE_QUICK, MODE_RINSE)
  - default tick constants
- Sub-module washer_tick_timer: loadable down-counter with enable (pause), zero flag and saturation. Instantiate it twice, once for the phase timer and once for the watchdog.

Test Plan:
Test parameters: WASH_TICKS=8, RINSE_TICKS=4, SPIN_TICKS=6, MAX_RINSE=3, FILL_LIMIT=20.
1. Normal run: mode=0, start+door_close, filled after 3 clocks, detergent after 2 → motor_on high exactly 8 clocks in WASH, one rinse of 4, spin 6 clocks, done=1, door unlocks.
2. Heavy run: mode=1 → three rinse passes; rinse_left reads 3,2,1,0; WASH-state entries observed = 4.
3. Quick and rinse-only: mode=2 gives a 4-clock soap wash; mode=3 never enters DETERGENT and soap_wash stays 0.
4. Fill watchdog: filled held 0 → fault=1 on clock 20 in FILL, drain_valve_on=1, door_lock drops after drained=1, only reset recovers.
5. Door opened mid-WASH → FAULT next clock. Async reset asserted mid-SPIN → all outputs 0 immediately, state=IDLE, no clock required.
6. (PAUSE_EN) pause for 5 clocks mid-WASH at count 3 → motor off; WASH total = 8+5 clocks; resume completes normally.

Source files
------------

// File: rtl/washer_pkg.sv
// washer_pkg: shared definitions for the programmable washing-machine controller.
//   - state_e   : 3-bit FSM state encoding (also driven out on the state port)
//   - MODE_*    : program select codes sampled on start
//   - DEF_*     : default tick / watchdog lengths in clocks
//   - ticks_to_load : converts a phase length in clocks into the value a
//                     down-counter must be loaded with so that the phase
//                     lasts exactly that many clocks (count N-1 .. 0).
package washer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FILL      = 3'd1,
    ST_DETERGENT = 3'd2,
    ST_WASH      = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_SPIN      = 3'd5,
    ST_DONE      = 3'd6,
    ST_FAULT     = 3'd7
  } state_e;

  localparam logic [1:0] MODE_NORMAL = 2'd0;
  localparam logic [1:0] MODE_HEAVY  = 2'd1;
  localparam logic [1:0] MODE_QUICK  = 2'd2;
  localparam logic [1:0] MODE_RINSE  = 2'd3;

  localparam int DEF_TIMER_W     = 16;
  localparam int DEF_WASH_TICKS  = 1000;
  localparam int DEF_RINSE_TICKS = 500;
  localparam int DEF_SPIN_TICKS  = 800;
  localparam int DEF_MAX_RINSE   = 3;
  localparam int DEF_FILL_LIMIT  = 2000;

  function automatic int ticks_to_load(input int n);
    return (n <= 0) ? 0 : n - 1;
  endfunction

endpackage

// File: rtl/washer_tick_timer.sv
// washer_tick_timer: loadable down-counter with enable and zero flag.
//   clk_i, rst_i : clock, asynchronous active-high reset (count -> 0)
//   load_i       : load load_val_i (has priority over counting)
//   load_val_i   : value to load
//   en_i         : count down by one per clock while enabled
//   zero_o       : count is zero
// The counter saturates at zero and never wraps.
module washer_tick_timer #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/washing_machine_prog.sv
// washing_machine_prog: programmable washing-machine controller.
// Runs FILL -> DETERGENT -> WASH -> DRAIN, then one or more rinse passes
// (FILL -> WASH -> DRAIN), then SPIN -> DONE. Mode (sampled on start)
// selects normal / heavy (MAX_RINSE rinses) / quick (half wash) / rinse-only.
// A phase timer sets WASH and SPIN lengths; a watchdog bounds FILL and DRAIN.
// Opening the door in a running state, or a watchdog expiry, goes to FAULT,
// which is left only through reset.
// Ports:
//   clock, reset            : clock, asynchronous active-high reset
//   door_close, start, mode : door sensor, start level, program select
//   filled, detergent_added, drained : drum / dispenser sensors
//   pause (PAUSE_EN only)   : freezes timers, stops motor and valves
//   door_lock, motor_on, fill_valve_on, drain_valve_on : actuators (registered)
//   soap_wash, water_wash, done, fault : status (registered)
//   state, rinse_left       : current FSM state and remaining rinse passes
// Build option: define PAUSE_EN to add the pause input.
module washing_machine_prog
  import washer_pkg::*;
#(
  parameter int TIMER_W     = DEF_TIMER_W,
  parameter int WASH_TICKS  = DEF_WASH_TICKS,
  parameter int RINSE_TICKS = DEF_RINSE_TICKS,
  parameter int SPIN_TICKS  = DEF_SPIN_TICKS,
  parameter int MAX_RINSE   = DEF_MAX_RINSE,
  parameter int FILL_LIMIT  = DEF_FILL_LIMIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       door_close,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       filled,
  input  logic       detergent_added,
  input  logic       drained,
`ifdef PAUSE_EN
  input  logic       pause,
`endif
  output logic       door_lock,
  output logic       motor_on,
  output logic       fill_valve_on,
  output logic       drain_valve_on,
  output logic       soap_wash,
  output logic       water_wash,
  output logic       done,
  output logic       fault,
  output logic [2:0] state,
  output logic [3:0] rinse_left
);

  localparam logic [TIMER_W-1:0] WASH_LOAD  = TIMER_W'(ticks_to_load(WASH_TICKS));
  localparam logic [TIMER_W-1:0] QUICK_LOAD = TIMER_W'(ticks_to_load(WASH_TICKS / 2));
  localparam logic [TIMER_W-1:0] RINSE_LOAD = TIMER_W'(ticks_to_load(RINSE_TICKS));
  localparam logic [TIMER_W-1:0] SPIN_LOAD  = TIMER_W'(ticks_to_load(SPIN_TICKS));
  localparam logic [TIMER_W-1:0] WD_LOAD    = TIMER_W'(ticks_to_load(FILL_LIMIT));
  localparam logic [3:0]         HEAVY_RINSES = 4'(MAX_RINSE);

  // Run enable: low while paused, freezing timers and stopping actuators.
  logic run_en;
`ifdef PAUSE_EN
  assign run_en = ~pause;
`else
  assign run_en = 1'b1;
`endif

  state_e       state_q, state_d;
  logic [1:0]   mode_q, mode_d;
  logic [3:0]   rinse_left_q, rinse_left_d;
  logic         soap_wash_q, soap_wash_d;
  // soap_pend: the soap wash of this run has not been done yet.
  logic         soap_pend_q, soap_pend_d;
  // rinse_pass: the current FILL/WASH/DRAIN pass is a rinse.
  logic         rinse_pass_q, rinse_pass_d;

  logic door_lock_q, motor_on_q, fill_valve_q, drain_valve_q;
  logic water_wash_q, done_q, fault_q;
  logic door_lock_d, motor_on_d, fill_valve_d, drain_valve_d;
  logic water_wash_d, done_d, fault_d;

  logic               ph_load, ph_en, ph_zero;
  logic               wd_load, wd_en, wd_zero;
  logic [TIMER_W-1:0] ph_load_val;
  logic               running;

  // Phase timer: WASH and SPIN lengths.
  washer_tick_timer #(.W(TIMER_W)) u_phase_timer (
    .clk_i      (clock),
    .rst_i      (reset),
    .load_i     (ph_load),
    .load_val_i (ph_load_val),
    .en_i       (ph_en),
    .zero_o     (ph_zero)
  );

  // Watchdog: bounds time spent in FILL and DRAIN.
  washer_tick_timer #(.W(TIMER_W)) u_watchdog (
    .clk_i      (clock),
    .rst_i      (reset),
    .load_i     (wd_load),
    .load_val_i (WD_LOAD),
    .en_i       (wd_en),
    .zero_o     (wd_zero)
  );

  assign running = state_q inside {ST_FILL, ST_DETERGENT, ST_WASH, ST_DRAIN, ST_SPIN};

  // Timers load on the edge that enters their state, so the first cycle in
  // the state already sees N-1 and the state lasts exactly N cycles.
  assign ph_load = (state_d != state_q) && ((state_d == ST_WASH) || (state_d == ST_SPIN));
  assign wd_load = (state_d != state_q) && ((state_d == ST_FILL) || (state_d == ST_DRAIN));
  assign ph_en   = run_en && ((state_q == ST_WASH) || (state_q == ST_SPIN));
  assign wd_en   = run_en && ((state_q == ST_FILL) || (state_q == ST_DRAIN));

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      mode_q        <= 2'd0;
      rinse_left_q  <= 4'd0;
      soap_wash_q   <= 1'b0;
      soap_pend_q   <= 1'b0;
      rinse_pass_q  <= 1'b0;
      door_lock_q   <= 1'b0;
      motor_on_q    <= 1'b0;
      fill_valve_q  <= 1'b0;
      drain_valve_q <= 1'b0;
      water_wash_q  <= 1'b0;
      done_q        <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      rinse_left_q  <= rinse_left_d;
      soap_wash_q   <= soap_wash_d;
      soap_pend_q   <= soap_pend_d;
      rinse_pass_q  <= rinse_pass_d;
      door_lock_q   <= door_lock_d;
      motor_on_q    <= motor_on_d;
      fill_valve_q  <= fill_valve_d;
      drain_valve_q <= drain_valve_d;
      water_wash_q  <= water_wash_d;
      done_q        <= done_d;
      fault_q       <= fault_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    rinse_left_d = rinse_left_q;
    soap_wash_d  = soap_wash_q;
    soap_pend_d  = soap_pend_q;
    rinse_pass_d = rinse_pass_q;
    ph_load_val  = '0;
    if (running && !door_close) begin
      // Door opened while latched and running: safety stop.
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && door_close) begin
            state_d      = ST_FILL;
            mode_d       = mode;
            rinse_left_d = (mode == MODE_HEAVY) ? HEAVY_RINSES : 4'd1;
            soap_wash_d  = (mode != MODE_RINSE);
            soap_pend_d  = (mode != MODE_RINSE);
            rinse_pass_d = 1'b0;
          end
        end
        ST_FILL: begin
          // filled is checked before the watchdog so it wins a tie.
          if (filled) begin
            if (soap_pend_q) begin
              state_d = ST_DETERGENT;
            end else begin
              state_d      = ST_WASH;
              rinse_pass_d = 1'b1;
              ph_load_val  = RINSE_LOAD;
            end
          end else if (wd_zero && run_en) begin
            state_d = ST_FAULT;
          end
        end
        ST_DETERGENT: begin
          if (detergent_added) begin
            state_d      = ST_WASH;
            rinse_pass_d = 1'b0;
            ph_load_val  = (mode_q == MODE_QUICK) ? QUICK_LOAD : WASH_LOAD;
          end
        end
        ST_WASH: begin
          if (ph_zero && run_en) begin
            state_d = ST_DRAIN;
            if (!rinse_pass_q) soap_pend_d = 1'b0;
          end
        end
        ST_DRAIN: begin
          if (drained) begin
            if (!rinse_pass_q) begin
              state_d = ST_FILL;
            end else begin
              if (rinse_left_q != 4'd0) rinse_left_d = rinse_left_q - 4'd1;
              if (rinse_left_d != 4'd0) begin
                state_d = ST_FILL;
              end else begin
                state_d     = ST_SPIN;
                ph_load_val = SPIN_LOAD;
              end
            end
          end else if (wd_zero && run_en) begin
            state_d = ST_FAULT;
          end
        end
        ST_SPIN: begin
          if (ph_zero && run_en) state_d = ST_DONE;
        end
        ST_DONE: begin
          if (!door_close) state_d = ST_IDLE;
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_FAULT;
        end
      endcase
    end
  end

  // Output logic: decoded from the state being entered, then registered.
  always_comb begin
    door_lock_d   = 1'b0;
    motor_on_d    = 1'b0;
    fill_valve_d  = 1'b0;
    drain_valve_d = 1'b0;
    water_wash_d  = 1'b0;
    done_d        = 1'b0;
    fault_d       = 1'b0;
    case (state_d)
      ST_FILL: begin
        door_lock_d  = 1'b1;
        fill_valve_d = run_en;
      end
      ST_DETERGENT: begin
        door_lock_d = 1'b1;
      end
      ST_WASH: begin
        door_lock_d  = 1'b1;
        motor_on_d   = run_en;
        water_wash_d = rinse_pass_d;
      end
      ST_DRAIN: begin
        door_lock_d   = 1'b1;
        drain_valve_d = run_en;
      end
      ST_SPIN: begin
        door_lock_d   = 1'b1;
        motor_on_d    = run_en;
        drain_valve_d = 1'b1;
      end
      ST_DONE: begin
        done_d      = 1'b1;
        door_lock_d = ~drained;
      end
      ST_FAULT: begin
        fault_d       = 1'b1;
        drain_valve_d = 1'b1;
        door_lock_d   = ~drained;
      end
      default: begin
        door_lock_d = 1'b0;
      end
    endcase
  end

  assign door_lock      = door_lock_q;
  assign motor_on       = motor_on_q;
  assign fill_valve_on  = fill_valve_q;
  assign drain_valve_on = drain_valve_q;
  assign soap_wash      = soap_wash_q;
  assign water_wash     = water_wash_q;
  assign done           = done_q;
  assign fault          = fault_q;
  assign state          = state_q;
  assign rinse_left     = rinse_left_q;

endmodule
